// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl_pkg
//  Description : Shared MD opcode encoding and MDU controller FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    // MD opcode encoding shared by decode, the controller and the HI/LO unit
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_DIV   = 4'd1;
    localparam logic [3:0] MD_DIVU  = 4'd2;
    localparam logic [3:0] MD_MULT  = 4'd3;
    localparam logic [3:0] MD_MULTU = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_LAST  = MD_MSUB;

    // Controller FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CALC = 1'b1;

    // True for the multi-cycle ops that occupy the HI/LO unit
    function automatic logic is_multicycle(input logic [3:0] md_type);
        logic hit;
        case (md_type)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MSUB: hit = 1'b1;
            default:                                     hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage : mdu_ctrl_pkg
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Multiply/divide issue controller. Tracks the busy period of
//                the HI/LO unit, stalls dependent MD ops, muxes mfhi/mflo
//                read data and keeps busy/issue performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_md_use,
    input  logic        e_valid,
    input  logic [3:0]  e_md_type,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    output logic [3:0]  mdu_type,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [31:0] md_rdata,
    output logic        stall,
    output logic [31:0] busy_cnt,
    output logic [31:0] op_cnt,
    output logic        illegal_op
);

    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Busy period length for an issued op; divides are the long ones
    function automatic logic [CNT_W-1:0] op_latency(input logic [3:0] md_type);
        logic [CNT_W-1:0] lat;
        if (md_type == MD_DIV || md_type == MD_DIVU) begin
            lat = CNT_W'(DIV_CYC);
        end else begin
            lat = CNT_W'(MUL_CYC);
        end
        return lat;
    endfunction

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_busy_cnt;
    logic [31:0]      r_op_cnt;
    logic             r_illegal;
    logic             w_idle;
    logic             w_issue;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_issue = w_idle & e_valid & is_multicycle(e_md_type);

    // Dependent MD ops in D wait until the unit has produced its result
    assign stall = d_md_use & (w_issue | (r_state == ST_CALC));

    // Drive the HI/LO unit only from a live E-stage op while the unit is free
    always_comb begin
        mdu_type = MD_NONE;
        mdu_a    = 32'd0;
        mdu_b    = 32'd0;
        if (e_valid && w_idle) begin
            mdu_type = e_md_type;
            mdu_a    = e_rs;
            mdu_b    = e_rt;
        end
    end

    // mfhi/mflo read mux for E-stage writeback
    always_comb begin
        md_rdata = 32'd0;
        if (e_md_type == MD_MFHI) begin
            md_rdata = hi_in;
        end else if (e_md_type == MD_MFLO) begin
            md_rdata = lo_in;
        end
    end

    // FSM and busy down-counter; flushes during CALC do not abort the op
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state <= ST_CALC;
                        r_cnt   <= op_latency(e_md_type);
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Performance counters, free-running with natural 32-bit wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_cnt <= 32'd0;
            r_op_cnt   <= 32'd0;
        end else begin
            if (r_state == ST_CALC) begin
                r_busy_cnt <= r_busy_cnt + 32'd1;
            end
            if (w_issue) begin
                r_op_cnt <= r_op_cnt + 32'd1;
            end
        end
    end

    // Sticky unsupported-opcode flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (e_valid && (e_md_type > MD_LAST)) begin
            r_illegal <= 1'b1;
        end
    end

    assign busy_cnt   = r_busy_cnt;
    assign op_cnt     = r_op_cnt;
    assign illegal_op = r_illegal;

endmodule : mdu_ctrl
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Directed self-checking bench for mdu_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        d_md_use;
    logic        e_valid;
    logic [3:0]  e_md_type;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [3:0]  mdu_type;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic [31:0] md_rdata;
    logic        stall;
    logic [31:0] busy_cnt;
    logic [31:0] op_cnt;
    logic        illegal_op;

    int total;
    int bad;
    int exp_op;
    int exp_busy;

    mdu_ctrl #(.MUL_CYC(5), .DIV_CYC(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_md_use   (d_md_use),
        .e_valid    (e_valid),
        .e_md_type  (e_md_type),
        .e_rs       (e_rs),
        .e_rt       (e_rt),
        .mdu_type   (mdu_type),
        .mdu_a      (mdu_a),
        .mdu_b      (mdu_b),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .md_rdata   (md_rdata),
        .stall      (stall),
        .busy_cnt   (busy_cnt),
        .op_cnt     (op_cnt),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] t, input logic [31:0] a,
                         input logic [31:0] b, input logic duse);
        e_valid   = v;
        e_md_type = t;
        e_rs      = a;
        e_rt      = b;
        d_md_use  = duse;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        hi_in = 32'd0;
        lo_in = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total++; if (busy_cnt !== 32'd0) begin bad++; $display("FAIL reset_busy got=%0d want=0", busy_cnt); end
        total++; if (op_cnt !== 32'd0) begin bad++; $display("FAIL reset_op got=%0d want=0", op_cnt); end
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal_op); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (mdu_type !== MD_NONE) begin bad++; $display("FAIL reset_mdu_type got=%0d want=0", mdu_type); end
        exp_op = 0;
        exp_busy = 0;
    endtask

    // mult at t=0 with a dependent op in D: stall t=0..5, free at t=6
    task automatic test_mult();
        drive(1'b1, MD_MULT, 32'd3, 32'd4, 1'b1);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mult_issue_stall got=%b want=1", stall); end
        total++; if (mdu_type !== MD_MULT || mdu_a !== 32'd3 || mdu_b !== 32'd4) begin
            bad++; $display("FAIL mult_issue_bus got=%0d/%h/%h want=3/3/4", mdu_type, mdu_a, mdu_b); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
            #1;
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL mult_stall_c%0d got=%b want=1", i, stall); end
        end
        tick();
        exp_op += 1;
        exp_busy += 5;
        hi_in = 32'd0;
        lo_in = 32'd12;
        drive(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mult_c6_stall got=%b want=0", stall); end
        total++; if (op_cnt !== 32'(exp_op)) begin bad++; $display("FAIL mult_op_cnt got=%0d want=%0d", op_cnt, exp_op); end
        total++; if (busy_cnt !== 32'(exp_busy)) begin bad++; $display("FAIL mult_busy_cnt got=%0d want=%0d", busy_cnt, exp_busy); end
        total++; if (md_rdata !== 32'd12) begin bad++; $display("FAIL mult_mflo got=%0d want=12", md_rdata); end
        tick();
    endtask

    // div 7/2 with mflo waiting in D; flushes and a stray mult mid-CALC
    task automatic test_div();
        int n;
        drive(1'b1, MD_DIV, 32'd7, 32'd2, 1'b1);
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            tick();
            if (n == 3) begin
                drive(1'b1, MD_MULT, 32'd9, 32'd9, 1'b1);
                #1;
                total++; if (mdu_type !== MD_NONE) begin bad++; $display("FAIL div_calc_mdu_type got=%0d want=0", mdu_type); end
            end else begin
                drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
                #1;
            end
        end
        total++; if (n !== 11) begin bad++; $display("FAIL div_stall_len got=%0d want=11", n); end
        exp_op += 1;
        exp_busy += 10;
        hi_in = 32'd1;
        lo_in = 32'd3;
        drive(1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0);
        #1;
        total++; if (md_rdata !== 32'd3) begin bad++; $display("FAIL div_mflo got=%0d want=3", md_rdata); end
        e_md_type = MD_MFHI;
        #1;
        total++; if (md_rdata !== 32'd1) begin bad++; $display("FAIL div_mfhi got=%0d want=1", md_rdata); end
        total++; if (op_cnt !== 32'(exp_op)) begin bad++; $display("FAIL div_op_cnt got=%0d want=%0d", op_cnt, exp_op); end
        total++; if (busy_cnt !== 32'(exp_busy)) begin bad++; $display("FAIL div_busy_cnt got=%0d want=%0d", busy_cnt, exp_busy); end
        tick();
    endtask

    task automatic test_mthi();
        drive(1'b1, MD_MTHI, 32'hDEADBEEF, 32'd5, 1'b1);
        #1;
        total++; if (mdu_type !== 4'd7) begin bad++; $display("FAIL mthi_type got=%0d want=7", mdu_type); end
        total++; if (mdu_a !== 32'hDEADBEEF) begin bad++; $display("FAIL mthi_a got=%h want=deadbeef", mdu_a); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mthi_stall got=%b want=0", stall); end
        total++; if (md_rdata !== 32'd0) begin bad++; $display("FAIL mthi_rdata got=%h want=0", md_rdata); end
        tick();
        drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        #1;
        total++; if (op_cnt !== 32'(exp_op)) begin bad++; $display("FAIL mthi_op_cnt got=%0d want=%0d", op_cnt, exp_op); end
    endtask

    task automatic test_flush();
        drive(1'b0, MD_MULT, 32'd6, 32'd7, 1'b1);
        #1;
        total++; if (mdu_type !== MD_NONE || mdu_a !== 32'd0 || mdu_b !== 32'd0) begin
            bad++; $display("FAIL flush_bus got=%0d/%h/%h want=0/0/0", mdu_type, mdu_a, mdu_b); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall); end
        tick();
        total++; if (op_cnt !== 32'(exp_op)) begin bad++; $display("FAIL flush_op_cnt got=%0d want=%0d", op_cnt, exp_op); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_next_stall got=%b want=0", stall); end
    endtask

    // msub without a dependent D op: unit busy, but pipeline runs on
    task automatic test_msub_no_use();
        drive(1'b1, MD_MSUB, 32'd2, 32'd3, 1'b0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL msub_issue_stall got=%b want=0", stall); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            drive(1'b1, MD_MTHI, 32'd1, 32'd0, 1'b0);
            #1;
            total++; if (mdu_type !== MD_NONE) begin bad++; $display("FAIL msub_calc_type_c%0d got=%0d want=0", i, mdu_type); end
        end
        tick();
        exp_op += 1;
        exp_busy += 5;
        #1;
        total++; if (mdu_type !== MD_MTHI) begin bad++; $display("FAIL msub_idle_type got=%0d want=7", mdu_type); end
        total++; if (busy_cnt !== 32'(exp_busy)) begin bad++; $display("FAIL msub_busy_cnt got=%0d want=%0d", busy_cnt, exp_busy); end
        total++; if (op_cnt !== 32'(exp_op)) begin bad++; $display("FAIL msub_op_cnt got=%0d want=%0d", op_cnt, exp_op); end
        drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        tick();
    endtask

    // divu interrupted by reset when its counter reads 3
    task automatic test_reset_mid();
        drive(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b1);
        tick();
        drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
        for (int i = 2; i <= 8; i++) tick();
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rstmid_pre_stall got=%b want=1", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, MD_MTHI, 32'h55, 32'd0, 1'b1);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b want=0", stall); end
        total++; if (mdu_type !== MD_MTHI) begin bad++; $display("FAIL rstmid_idle got=%0d want=7", mdu_type); end
        total++; if (busy_cnt !== 32'd0 || op_cnt !== 32'd0) begin
            bad++; $display("FAIL rstmid_cnts got=%0d/%0d want=0/0", busy_cnt, op_cnt); end
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL rstmid_illegal got=%b want=0", illegal_op); end
        tick();
    endtask

    task automatic test_illegal();
        drive(1'b0, 4'd12, 32'd0, 32'd0, 1'b0);
        tick();
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL illegal_flushed got=%b want=0", illegal_op); end
        drive(1'b1, 4'd12, 32'd0, 32'd0, 1'b1);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL illegal_stall got=%b want=0", stall); end
        tick();
        drive(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            #1;
            total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL illegal_hold_c%0d got=%b want=1", i, illegal_op); end
            tick();
        end
        total++; if (op_cnt !== 32'd0) begin bad++; $display("FAIL illegal_op_cnt got=%0d want=0", op_cnt); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_mult();
        test_div();
        test_mthi();
        test_flush();
        test_msub_no_use();
        test_reset_mid();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mdu_ctrl
`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYC, default 5, meaning mult/multu/msub latency in cycles.
REQ-002 SHALL have parameter DIV_CYC, default 10, meaning div/divu latency in cycles.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port d_md_use, input, 1, D-stage instruction is any MD op (mult..msub, mfhi/mflo/mthi/mtlo).
REQ-006 SHALL have port e_valid, input, 1, E-stage instruction is valid (not bubble/flushed).
REQ-007 SHALL have port e_md_type, input, 4, E-stage MD opcode (shared encoding, 0=none .. 9=msub).
REQ-008 SHALL have ports e_rs and e_rt, input, 32 each, forwarded E-stage operands.
REQ-009 SHALL have ports mdu_type (4), mdu_a (32), mdu_b (32), output, driven to the HI/LO unit.
REQ-010 SHALL have ports hi_in and lo_in, input, 32 each, current HI/LO register values.
REQ-011 SHALL have port md_rdata, output, 32, mfhi/mflo read value for E-stage writeback.
REQ-012 SHALL have port stall, output, 1, freeze F/D and bubble E.
REQ-013 SHALL have ports busy_cnt and op_cnt, output, 32 each, performance counters.
REQ-014 SHALL have port illegal_op, output, 1, sticky flag for an unsupported opcode.

Function
REQ-015 SHALL implement FSM states IDLE and CALC with a down-counter cnt.
REQ-016 SHALL define issue = IDLE & e_valid & e_md_type in {mult, multu, div, divu, msub}.
REQ-017 On issue, SHALL enter CALC with cnt=MUL_CYC for mult/multu/msub and cnt=DIV_CYC for div/divu.
REQ-018 In CALC, SHALL decrement cnt each cycle and return to IDLE on the cycle after cnt==1.
REQ-019 SHALL drive mdu_type=e_md_type, mdu_a=e_rs, mdu_b=e_rt when e_valid is 1 and state is IDLE; otherwise mdu_type=none and mdu_a=mdu_b=0.
REQ-020 SHALL compute stall = d_md_use & (issue | CALC), combinationally.
REQ-021 For an issue at cycle t with latency N, stall SHALL be asserted for cycles t..t+N, and a D-stage mfhi/mflo SHALL reach E at t+N+1 and see the updated HI/LO.
REQ-022 md_rdata SHALL equal hi_in for mfhi, lo_in for mflo, and 0 otherwise.
REQ-023 mthi/mtlo in IDLE SHALL pass through in the same cycle with no stall; these ops cannot occur in CALC because of REQ-020.
REQ-024 e_valid=0 (flush) SHALL suppress issue; a flush during CALC SHALL NOT abort the operation.
REQ-025 busy_cnt SHALL increment every cycle in CALC and op_cnt SHALL increment on every issue; both SHALL wrap modulo 2^32.
REQ-026 illegal_op SHALL set when e_valid=1 and e_md_type>9, and SHALL clear only on reset.
REQ-027 Simultaneous d_md_use and issue SHALL stall in the issue cycle.

Reset
REQ-028 On reset, state=IDLE, cnt=0, busy_cnt=0, op_cnt=0, illegal_op=0, and stall SHALL deassert the following cycle.
REQ-029 A reset during CALC SHALL abandon the operation immediately; the HI/LO unit is reset on the same signal.

Structure
REQ-030 The MD opcode constants (none=0, div=1, divu=2, mult=3, multu=4, mfhi=5, mflo=6, mthi=7, mtlo=8, msub=9) and the FSM state encoding SHALL live in the shared package.
REQ-031 SHALL be a single module with no sub-modules; the latency lookup SHALL be a local function.

Verification
REQ-032 The bench SHALL cover: mult issued at t=0 with d_md_use=1 -> stall high for t=0..5, low at t=6, op_cnt=1, busy_cnt=5.
REQ-033 The bench SHALL cover: div followed by mflo in D -> stall for 11 cycles, then md_rdata=lo_in of the quotient (7/2 -> 3).
REQ-034 The bench SHALL cover: mthi with e_rs=0xDEADBEEF in IDLE -> mdu_type=7, mdu_a=0xDEADBEEF, stall=0.
REQ-035 The bench SHALL cover: e_valid=0 with e_md_type=mult -> no issue, mdu_type=0, op_cnt unchanged.
REQ-036 The bench SHALL cover: reset asserted at cnt=3 of divu -> the next cycle has state IDLE, stall=0, all counters 0.
REQ-037 The bench SHALL cover: e_md_type=12 with e_valid=1 -> illegal_op=1 and held through 20 idle cycles.
